cic_decim_ctrl: RTL and testbench



---
 rtl/cic_decim_ctrl.sv | 130 +++++++++++++
 tb/tb_cic_decim_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: builds the dump strobe from the sample enable and owns the
// active decimation/shift, swapping them only at a period boundary followed by clear and flush.
module cic_decim_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned FLUSH_OUTPUTS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkEn,
    input  logic [14:0] cicDecimation,
    input  logic [5:0]  cicShift,
    output logic        decimEn,
    output logic        dataValid,
    output logic        intClear,
    output logic [14:0] activeDecimation,
    output logic [5:0]  activeShift,
    output logic        busy
);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned FW = $clog2(FLUSH_OUTPUTS + 1);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_PEND  = 2'd3;

    logic [1:0]    r_state;
    logic [14:0]   r_cnt;
    logic [SW-1:0] r_settle;
    logic [FW-1:0] r_flush;
    logic [14:0]   r_prev_dec;
    logic [5:0]    r_prev_shift;
    logic          r_decim_en;
    logic          r_data_valid;
    logic          r_int_clear;
    logic [14:0]   r_active_dec;
    logic [5:0]    r_active_shift;

    logic [1:0]    w_state_next;
    logic [14:0]   w_dreq;
    logic          w_diff;
    logic          w_bus_moved;
    logic          w_chg;
    logic          w_last;
    logic          w_period_end;

    assign w_dreq       = (cicDecimation == 15'd0) ? 15'd1 : cicDecimation;
    assign w_diff       = (w_dreq != r_active_dec) || (cicShift != r_active_shift);
    assign w_bus_moved  = (cicDecimation != r_prev_dec) || (cicShift != r_prev_shift);
    assign w_chg        = w_diff && (r_settle == SW'(SETTLE_CYCLES));
    assign w_last       = (r_cnt == r_active_dec - 15'd1);
    // Samples landing on the LOAD clock are discarded so the new period starts clean.
    assign w_period_end = clkEn && (r_state != ST_LOAD) && w_last;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD:  w_state_next = ST_FLUSH;
            ST_FLUSH: begin
                if (w_period_end && (r_flush == FW'(FLUSH_OUTPUTS - 1))) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clkEn && w_chg) begin
                    w_state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                // A reverted bus wins over a coincident period end: nothing to load.
                if (clkEn) begin
                    if (!w_diff) begin
                        w_state_next = ST_RUN;
                    end else if (w_period_end) begin
                        w_state_next = ST_LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_LOAD;
            r_cnt          <= 15'd0;
            r_settle       <= '0;
            r_flush        <= '0;
            r_prev_dec     <= 15'd0;
            r_prev_shift   <= 6'd0;
            r_decim_en     <= 1'b0;
            r_data_valid   <= 1'b0;
            r_int_clear    <= 1'b0;
            r_active_dec   <= 15'd1;
            r_active_shift <= 6'd0;
        end else begin
            r_state      <= w_state_next;
            r_prev_dec   <= cicDecimation;
            r_prev_shift <= cicShift;
            if (w_bus_moved) begin
                r_settle <= '0;
            end else if (r_settle != SW'(SETTLE_CYCLES)) begin
                r_settle <= r_settle + SW'(1);
            end
            r_int_clear  <= (r_state == ST_LOAD);
            r_decim_en   <= w_period_end;
            r_data_valid <= w_period_end && ((r_state == ST_RUN) || (r_state == ST_PEND));
            if (r_state == ST_LOAD) begin
                r_active_dec   <= w_dreq;
                r_active_shift <= cicShift;
                r_cnt          <= 15'd0;
                r_flush        <= '0;
            end else begin
                if (clkEn) begin
                    r_cnt <= w_last ? 15'd0 : r_cnt + 15'd1;
                end
                if ((r_state == ST_FLUSH) && w_period_end) begin
                    r_flush <= r_flush + FW'(1);
                end
            end
        end
    end

    assign decimEn          = r_decim_en;
    assign dataValid        = r_data_valid;
    assign intClear         = r_int_clear;
    assign activeDecimation = r_active_dec;
    assign activeShift      = r_active_shift;
    assign busy             = (r_state != ST_RUN);

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl: directed scenarios plus random traffic,
// compared every clock against a behavioural model built from the period/settle/flush rules.
module tb_cic_decim_ctrl;
    localparam int SETTLE = 4;
    localparam int FLUSH  = 4;
    localparam int M_LOAD = 0, M_FLUSH = 1, M_RUN = 2, M_PEND = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clkEn = 1'b0;
    logic [14:0] cicDecimation = 15'd0;
    logic [5:0]  cicShift = 6'd0;
    logic        decimEn, dataValid, intClear, busy;
    logic [14:0] activeDecimation;
    logic [5:0]  activeShift;

    int checks = 0;
    int errors = 0;

    int m_mode, m_dec, m_sh, m_cnt, m_settle, m_prev_dec, m_prev_sh, m_flushed;
    bit m_strobe, m_valid, m_clear;

    cic_decim_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .FLUSH_OUTPUTS(FLUSH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .clkEn            (clkEn),
        .cicDecimation    (cicDecimation),
        .cicShift         (cicShift),
        .decimEn          (decimEn),
        .dataValid        (dataValid),
        .intClear         (intClear),
        .activeDecimation (activeDecimation),
        .activeShift      (activeShift),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // One clock of the reference behaviour, evaluated with the inputs present at the edge.
    task automatic model_edge();
        int dreq, mode;
        bit diff, chg, pe;
        if (reset) begin
            m_mode = M_LOAD; m_dec = 1; m_sh = 0; m_cnt = 0; m_settle = 0;
            m_prev_dec = 0; m_prev_sh = 0; m_flushed = 0;
            m_strobe = 0; m_valid = 0; m_clear = 0;
            return;
        end
        dreq = (cicDecimation == 15'd0) ? 1 : int'(cicDecimation);
        diff = (dreq != m_dec) || (int'(cicShift) != m_sh);
        chg  = diff && (m_settle == SETTLE);
        pe   = clkEn && (m_mode != M_LOAD) && (((m_cnt + 1) % m_dec) == 0);
        mode = m_mode;
        m_clear  = (mode == M_LOAD);
        m_strobe = pe;
        m_valid  = pe && (mode == M_RUN || mode == M_PEND);
        if (int'(cicDecimation) != m_prev_dec || int'(cicShift) != m_prev_sh) m_settle = 0;
        else if (m_settle < SETTLE) m_settle++;
        m_prev_dec = int'(cicDecimation);
        m_prev_sh  = int'(cicShift);
        if (mode == M_LOAD) begin
            m_dec = dreq; m_sh = int'(cicShift); m_cnt = 0; m_flushed = 0; m_mode = M_FLUSH;
        end else begin
            if (clkEn) m_cnt = (m_cnt + 1) % m_dec;
            if (mode == M_FLUSH && pe) begin
                m_flushed++;
                if (m_flushed == FLUSH) m_mode = M_RUN;
            end else if (mode == M_RUN && clkEn && chg) begin
                m_mode = M_PEND;
            end else if (mode == M_PEND && clkEn) begin
                if (!diff) m_mode = M_RUN;
                else if (pe) m_mode = M_LOAD;
            end
        end
    endtask

    function automatic logic [24:0] obs_vec();
        return {decimEn, dataValid, intClear, busy, activeDecimation, activeShift};
    endfunction

    function automatic logic [24:0] exp_vec();
        return {m_strobe, m_valid, m_clear, (m_mode != M_RUN), 15'(m_dec), 6'(m_sh)};
    endfunction

    task automatic cyc(input logic en);
        clkEn = en;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Drive a new bus config and clock until the model has loaded it and is running again.
    task automatic apply_cfg(input int dec, input int sh);
        bit seen_load = 0;
        cicDecimation = 15'(dec);
        cicShift = 6'(sh);
        for (int k = 0; k < 2000; k++) begin
            cyc(1);
            if (m_mode == M_FLUSH) seen_load = 1;
            if (seen_load && m_mode == M_RUN) break;
        end
    endtask

    task automatic test_reset();
        int strobes = 0;
        reset = 1; cicDecimation = 15'd8; cicShift = 6'd3;
        repeat (3) cyc(1);
        checks++;
        if (obs_vec() !== {1'b0, 1'b0, 1'b0, 1'b1, 15'd1, 6'd0}) begin
            errors++; $display("FAIL reset_values got %h want %h", obs_vec(),
                               {1'b0, 1'b0, 1'b0, 1'b1, 15'd1, 6'd0});
        end
        reset = 0;
        cyc(1);
        checks++;
        if ({intClear, activeDecimation, activeShift} !== {1'b1, 15'd8, 6'd3}) begin
            errors++; $display("FAIL load_after_reset got clr=%b d=%0d s=%0d want 1/8/3",
                               intClear, activeDecimation, activeShift);
        end
        for (int k = 0; k < 60; k++) begin
            cyc(1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_reset got %h want %h", obs_vec(), exp_vec());
            end
            if (decimEn) begin
                strobes++;
                checks++;
                if (dataValid !== (strobes > FLUSH) || busy !== (strobes < FLUSH)) begin
                    errors++; $display("FAIL flush_gate strobe %0d got dv=%b busy=%b", strobes,
                                       dataValid, busy);
                end
            end
        end
        checks++;
        if (strobes != 7) begin
            errors++; $display("FAIL strobe_count got %0d want 7", strobes);
        end
    endtask

    task automatic test_decim_zero();
        int clears = 0;
        logic en;
        cicDecimation = 15'd0;
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            if (intClear) clears++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_d0 got %h want %h", obs_vec(), exp_vec());
            end
        end
        checks++;
        if (clears != 1 || {busy, activeDecimation} !== {1'b0, 15'd1}) begin
            errors++; $display("FAIL d0_load got clears=%0d busy=%b d=%0d want 1/0/1", clears,
                               busy, activeDecimation);
        end
        for (int k = 0; k < 16; k++) begin
            en = 1'($urandom_range(0, 1));
            cyc(en);
            checks++;
            if ({decimEn, dataValid} !== {en, en}) begin
                errors++; $display("FAIL d1_follow got %b%b want %b%b", decimEn, dataValid,
                                   en, en);
            end
        end
    endtask

    task automatic test_two_byte_write();
        int clears = 0, clear_at = -1;
        apply_cfg(8, 3);
        checks++;
        if (obs_vec() !== exp_vec() || busy !== 1'b0) begin
            errors++; $display("FAIL cfg8 got %h want %h", obs_vec(), exp_vec());
        end
        cicDecimation = 15'h0110;
        cyc(1); cyc(1);
        cicDecimation = 15'h0010;
        for (int k = 0; k < 110; k++) begin
            cyc(1);
            if (intClear) begin
                clears++;
                if (clear_at < 0) clear_at = k;
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_2byte got %h want %h", obs_vec(), exp_vec());
            end
        end
        checks++;
        if (clears != 1 || clear_at < SETTLE + 1 || activeDecimation !== 15'd16 ||
            busy !== 1'b0) begin
            errors++; $display("FAIL two_byte got clears=%0d at=%0d d=%0d busy=%b want 1/>=5/16/0",
                               clears, clear_at, activeDecimation, busy);
        end
    endtask

    task automatic test_shift_revert();
        int clears = 0;
        apply_cfg(100, 3);
        cicShift = 6'd5;
        for (int k = 0; k < SETTLE + 3; k++) begin
            cyc(1);
            if (intClear) clears++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_revert got %h want %h", obs_vec(), exp_vec());
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL pend_entry got busy=%b want 1", busy);
        end
        cicShift = 6'd3;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (intClear) clears++;
        end
        checks++;
        if (clears != 0 || busy !== 1'b0 || activeShift !== 6'd3) begin
            errors++; $display("FAIL revert got clears=%0d busy=%b s=%0d want 0/0/3", clears,
                               busy, activeShift);
        end
    endtask

    task automatic test_slow_rate();
        int ph = 0, clear_at = -1, strobes = 0;
        logic en;
        apply_cfg(4, 3);
        for (int k = 0; k < 60; k++) begin
            en = (ph % 3 == 0); ph++;
            cyc(en);
            if (en && m_cnt == 2 && m_mode == M_RUN) break;
        end
        cicShift = 6'd6;
        for (int k = 1; k <= 30; k++) begin
            en = (ph % 3 == 0); ph++;
            cyc(en);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_slow got %h want %h", obs_vec(), exp_vec());
            end
            if (k == 6) begin
                checks++;
                if ({decimEn, dataValid, busy, activeShift} !== {1'b1, 1'b1, 1'b1, 6'd3}) begin
                    errors++; $display("FAIL coincident_chg got de=%b dv=%b busy=%b s=%0d",
                                       decimEn, dataValid, busy, activeShift);
                end
            end
            if (clear_at < 0) begin
                if (decimEn) strobes++;
                if (intClear) clear_at = k;
            end
        end
        checks++;
        if (clear_at != 19 || strobes != 2 || activeShift !== 6'd6) begin
            errors++; $display("FAIL deferred_load got at=%0d strobes=%0d s=%0d want 19/2/6",
                               clear_at, strobes, activeShift);
        end
    endtask

    task automatic test_reset_flush();
        int strobes = 0;
        cicShift = 6'd1;
        for (int k = 0; k < 200; k++) begin
            cyc(1);
            if (m_mode == M_FLUSH && m_flushed == 2) break;
        end
        reset = 1;
        cyc(1);
        checks++;
        if ({decimEn, dataValid, intClear, busy, activeDecimation} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 15'd1}) begin
            errors++; $display("FAIL mid_flush_reset got de=%b busy=%b clr=%b d=%0d", decimEn,
                               busy, intClear, activeDecimation);
        end
        reset = 0;
        cyc(1);
        checks++;
        if ({intClear, activeDecimation, activeShift} !== {1'b1, 15'd4, 6'd1}) begin
            errors++; $display("FAIL reload got clr=%b d=%0d s=%0d want 1/4/1", intClear,
                               activeDecimation, activeShift);
        end
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_rflush got %h want %h", obs_vec(), exp_vec());
            end
            if (decimEn) begin
                strobes++;
                checks++;
                if (dataValid !== (strobes > FLUSH)) begin
                    errors++; $display("FAIL flush_restart strobe %0d got dv=%b", strobes,
                                       dataValid);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                cicDecimation = 15'($urandom_range(0, 6));
                cicShift = 6'($urandom_range(0, 63));
            end
            reset = ($urandom_range(0, 999) == 0);
            cyc(1'($urandom_range(0, 1)));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL model_random got %h want %h", obs_vec(), exp_vec());
            end
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_decim_zero();
        test_two_byte_write();
        test_shift_revert();
        test_slow_rate();
        test_reset_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
